scalar_wb_arbiter: RTL and testbench
====================================

// Module: scalar_wb_arbiter
// PURPOSE
//  Shares the single write port of scalarRegisterFile between NUM_REQ writeback requesters
//  (e.g. scalar ALU, load unit). Arbitrates per cycle and registers the grant into a
//  one-deep write stage that drives regWrEn/regToWrite/dataIn.
//  Sits between the execute/memory writeback sources and the scalar register file.
// PARAMETERS
//  registerSize   8  data width of one scalar register
//  selectionBits  3  register index width
//  NUM_REQ        2  number of writeback requesters (>=2)
// PORTS
//  clk         in   1                       clock
//  reset       in   1                       synchronous, active-low reset
//  wbStall     in   1                       1 = grant nothing this cycle
//  reqValid    in   NUM_REQ                 requester i has a write pending
//  reqReg      in   NUM_REQ*selectionBits   destination register per requester
//  reqData     in   NUM_REQ*registerSize    write data per requester
//  reqReady    out  NUM_REQ                 one-hot grant; transfer when valid&ready
//  regWrEn     out  1                       write strobe to register file
//  regToWrite  out  selectionBits           destination register to register file
//  dataIn      out  registerSize            write data to register file
//  grantCount  out  16                      total accepted writes, wraps at 2^16
// BEHAVIOUR
//  - Reset (reset==0 at posedge clk): regWrEn=0, regToWrite=0, dataIn=0, grantCount=0,
//    RR pointer=0. reqReady is combinational and is 0 while reset==0.
//  - reqReady: combinational from reqValid, wbStall and the pointer. At most one bit is set.
//    It is all-zero when wbStall=1 or no reqValid. It never asserts for a non-valid requester.
//  - Handshake: requester i transfers when reqValid[i]&reqReady[i]. It holds
//    reqValid/reqReg/reqData stable until it is granted.
//  - Latency 1: a grant in cycle N gives regWrEn=1 with that reg/data in cycle N+1.
//    With no grant in N, regWrEn=0 in N+1. regToWrite/dataIn hold their last values.
//  - Full throughput: one write per cycle. Back-to-back grants are allowed, incl. to the same register.
//  - Same destination from two requesters in one cycle: only the winner is granted.
//    The loser waits, so the later write lands one cycle after the first (program order is the requesters' problem).
//  - Pointer: after a grant to i, the pointer becomes (i+1) mod NUM_REQ and wraps at NUM_REQ-1.
//    With no grant, the pointer is unchanged.
//  - grantCount += 1 per accepted grant. It wraps 0xFFFF -> 0x0000.
//  - Reset mid-operation: an in-flight write stage is discarded (regWrEn=0 next cycle).
//    An un-granted request is simply re-presented after reset.
//  - Outputs change only on posedge clk, so they are stable for the file's gated write clock.
// CONFIGURATION
//  SCALAR_WB_RR_EN defined: round-robin. Search starts at the pointer and the first valid requester wins.
//  SCALAR_WB_RR_EN undefined: fixed priority, lowest index wins. The pointer register is removed.
//    Starvation of high indices is allowed; all other behaviour is identical.
// STRUCTURE
//  Package scalar_wb_pkg: NUM_REQ_DEFAULT, typedef req_idx_t (clog2 NUM_REQ bits),
//    function next_ptr(idx) for the wrap-around increment.
//  Sub-module wb_rr_grant: combinational one-hot grant from valid vector + pointer + stall.
//    Under fixed priority it degrades to a priority encoder.
//  Top holds the pointer, write-stage registers, grantCount and the reset logic.
// TESTING
//  1 reset=0 with reqValid=2'b11 -> reqReady=0; next cycle regWrEn=0, grantCount=0.
//  2 only req1 valid (reg 5, data 0xA5) -> reqReady=2'b10; next cycle regWrEn=1,
//    regToWrite=5, dataIn=0xA5.
//  3 RR on: both valid for 4 cycles, pointer=0 -> grants 01,10,01,10; grantCount=4.
//    RR off: grants 01,01,01,01.
//  4 both valid, both reg 3, data 0x11/0x22 -> writes 0x11 then 0x22 on consecutive
//    cycles (RR on, ptr=0).
//  5 wbStall=1 for 3 cycles with requests pending -> reqReady=0, regWrEn=0.
//    Grant resumes the cycle stall drops.
//  6 grantCount preset via 65535 grants, one more grant -> grantCount=0.
//    Then reset mid-write -> regWrEn=0 next cycle.

Source files
------------

// File: rtl/scalar_wb_pkg.sv
// Shared types and helpers for the scalar writeback arbiter.
// Round-robin arbitration is selected with SCALAR_WB_RR_EN; fixed priority otherwise.

package scalar_wb_pkg;

   localparam int unsigned NUM_REQ_DEFAULT = 2;
   localparam int unsigned REQ_IDX_W       = (NUM_REQ_DEFAULT > 1) ? $clog2(NUM_REQ_DEFAULT) : 1;

   typedef logic [REQ_IDX_W-1:0] req_idx_t;

   // Wrap-around increment of a requester index.
   function automatic int unsigned next_ptr(input int unsigned idx,
                                            input int unsigned num_req = NUM_REQ_DEFAULT);
      if (idx + 1 >= num_req) begin
         return 0;
      end
      return idx + 1;
   endfunction

endpackage

// File: rtl/wb_rr_grant.sv
// Combinational one-hot grant for the writeback arbiter. With SCALAR_WB_RR_EN defined the
// search starts at i_ptr; otherwise it is a plain lowest-index priority encoder.

module wb_rr_grant
   import scalar_wb_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT
) (
`ifdef SCALAR_WB_RR_EN
   input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
`endif
   input  logic [NUM_REQ-1:0]         i_valid,
   input  logic                       i_stall,
   output logic [NUM_REQ-1:0]         o_grant,
   output logic [$clog2(NUM_REQ)-1:0] o_idx,
   output logic                       o_any
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);

   always_comb begin
      logic [IdxW-1:0] cand;
      cand    = '0;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      if (!i_stall) begin
         for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SCALAR_WB_RR_EN
            cand = IdxW'((int'(i_ptr) + k) % NUM_REQ);
`else
            cand = IdxW'(k);
`endif
            if (!o_any && i_valid[cand]) begin
               o_grant[cand] = 1'b1;
               o_idx         = cand;
               o_any         = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Arbitrates NUM_REQ writeback requesters onto the scalar register file write port through a
// one-deep registered write stage. Define SCALAR_WB_RR_EN for round-robin; default is fixed priority.

module scalar_wb_arbiter
   import scalar_wb_pkg::*;
#(
   parameter int unsigned registerSize  = 8,
   parameter int unsigned selectionBits = 3,
   parameter int unsigned NUM_REQ       = NUM_REQ_DEFAULT
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               wbStall,
   input  logic [NUM_REQ-1:0]                 reqValid,
   input  logic [NUM_REQ*selectionBits-1:0]   reqReg,
   input  logic [NUM_REQ*registerSize-1:0]    reqData,
   output logic [NUM_REQ-1:0]                 reqReady,
   output logic                               regWrEn,
   output logic [selectionBits-1:0]           regToWrite,
   output logic [registerSize-1:0]            dataIn,
   output logic [15:0]                        grantCount
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);

   logic                     w_stall;
   logic [NUM_REQ-1:0]       w_grant;
   logic [IdxW-1:0]          w_grant_idx;
   logic                     w_grant_any;
   logic [selectionBits-1:0] w_sel_reg;
   logic [registerSize-1:0]  w_sel_data;

   logic                     r_wr_en;
   logic [selectionBits-1:0] r_wr_reg;
   logic [registerSize-1:0]  r_wr_data;
   logic [15:0]              r_grant_cnt;

   logic                     w_wr_en_d;
   logic [selectionBits-1:0] w_wr_reg_d;
   logic [registerSize-1:0]  w_wr_data_d;
   logic [15:0]              w_grant_cnt_d;

   // Holding reset suppresses grants so nothing is accepted while the stage is cleared.
   assign w_stall = wbStall | ~reset;

`ifdef SCALAR_WB_RR_EN
   logic [IdxW-1:0] r_ptr;
   logic [IdxW-1:0] w_ptr_d;
`endif

   wb_rr_grant #(
      .NUM_REQ (NUM_REQ)
   ) u_grant (
`ifdef SCALAR_WB_RR_EN
      .i_ptr   (r_ptr),
`endif
      .i_valid (reqValid),
      .i_stall (w_stall),
      .o_grant (w_grant),
      .o_idx   (w_grant_idx),
      .o_any   (w_grant_any)
   );

   assign reqReady = w_grant;

   assign w_sel_reg  = reqReg[w_grant_idx*selectionBits +: selectionBits];
   assign w_sel_data = reqData[w_grant_idx*registerSize +: registerSize];

   always_comb begin
      w_wr_en_d     = w_grant_any;
      w_wr_reg_d    = r_wr_reg;
      w_wr_data_d   = r_wr_data;
      w_grant_cnt_d = r_grant_cnt;
      if (w_grant_any) begin
         w_wr_reg_d    = w_sel_reg;
         w_wr_data_d   = w_sel_data;
         w_grant_cnt_d = r_grant_cnt + 16'd1;
      end
   end

`ifdef SCALAR_WB_RR_EN
   always_comb begin
      w_ptr_d = r_ptr;
      if (w_grant_any) begin
         w_ptr_d = IdxW'(next_ptr(32'(w_grant_idx), NUM_REQ));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ptr <= '0;
      end else begin
         r_ptr <= w_ptr_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_en     <= 1'b0;
         r_wr_reg    <= '0;
         r_wr_data   <= '0;
         r_grant_cnt <= '0;
      end else begin
         r_wr_en     <= w_wr_en_d;
         r_wr_reg    <= w_wr_reg_d;
         r_wr_data   <= w_wr_data_d;
         r_grant_cnt <= w_grant_cnt_d;
      end
   end

   assign regWrEn    = r_wr_en;
   assign regToWrite = r_wr_reg;
   assign dataIn     = r_wr_data;
   assign grantCount = r_grant_cnt;

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Bench for scalar_wb_arbiter: vector table plus hand sequences, with a write scoreboard.
module tb_scalar_wb_arbiter;
   import scalar_wb_pkg::*;

`ifdef SCALAR_WB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        wbStall;
   logic [1:0]  reqValid;
   logic [5:0]  reqReg;
   logic [15:0] reqData;
   logic [1:0]  reqReady;
   logic        regWrEn;
   logic [2:0]  regToWrite;
   logic [7:0]  dataIn;
   logic [15:0] grantCount;

   always #5 clk = ~clk;

   scalar_wb_arbiter #(
      .registerSize  (8),
      .selectionBits (3),
      .NUM_REQ       (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wbStall    (wbStall),
      .reqValid   (reqValid),
      .reqReg     (reqReg),
      .reqData    (reqData),
      .reqReady   (reqReady),
      .regWrEn    (regWrEn),
      .regToWrite (regToWrite),
      .dataIn     (dataIn),
      .grantCount (grantCount)
   );

   typedef struct {
      logic        rst_n;
      logic        stall;
      logic [1:0]  valid;
      logic [5:0]  regs;
      logic [15:0] data;
      logic [1:0]  rdy_fp;
      logic [1:0]  rdy_rr;
   } vec_t;

   typedef struct {
      logic [2:0] r;
      logic [7:0] d;
   } wr_t;

   vec_t        vecs[14];
   wr_t         sb_q[$];
   int          total = 0;
   int          bad = 0;
   req_idx_t    m_ptr;
   logic [15:0] m_cnt;
   logic [2:0]  m_last_reg;
   logic [7:0]  m_last_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: check reqReady against the model, push the expected write, then check outputs.
   task automatic cycle(input bit use_tbl, input logic [1:0] tbl_rdy);
      logic [1:0] eg;
      logic       w;
      logic       exp_wr;
      wr_t        e;
      #2;
      eg = 2'b00;
      if (reset === 1'b1 && wbStall === 1'b0) begin
         for (int k = 0; k < 2; k++) begin
            w = RR ? (m_ptr + 1'(k)) : 1'(k);
            if (eg == 2'b00 && reqValid[w]) eg[w] = 1'b1;
         end
      end
      chk("ready_model", {30'd0, reqReady}, {30'd0, eg});
      if (use_tbl) chk("ready_table", {30'd0, reqReady}, {30'd0, tbl_rdy});
      exp_wr = (eg != 2'b00);
      if (exp_wr) begin
         e.r = eg[1] ? reqReg[5:3] : reqReg[2:0];
         e.d = eg[1] ? reqData[15:8] : reqData[7:0];
         sb_q.push_back(e);
         m_cnt = m_cnt + 16'd1;
         m_ptr = eg[1] + 1'b1;
      end
      if (reset !== 1'b1) begin
         sb_q.delete();
         m_cnt       = 16'd0;
         m_ptr       = '0;
         m_last_reg  = 3'd0;
         m_last_data = 8'd0;
      end
      @(posedge clk);
      #1;
      chk("wr_en", {31'd0, regWrEn}, {31'd0, exp_wr});
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (regWrEn === 1'b1) begin
            chk("wr_reg", {29'd0, regToWrite}, {29'd0, e.r});
            chk("wr_data", {24'd0, dataIn}, {24'd0, e.d});
         end
         m_last_reg  = e.r;
         m_last_data = e.d;
      end else begin
         chk("hold_reg", {29'd0, regToWrite}, {29'd0, m_last_reg});
         chk("hold_data", {24'd0, dataIn}, {24'd0, m_last_data});
      end
      chk("grant_cnt", {16'd0, grantCount}, {16'd0, m_cnt});
   endtask

   task automatic apply(input vec_t v);
      reset    = v.rst_n;
      wbStall  = v.stall;
      reqValid = v.valid;
      reqReg   = v.regs;
      reqData  = v.data;
      cycle(1'b1, RR ? v.rdy_rr : v.rdy_fp);
   endtask

   initial begin
      //           rst   stall  valid  regs   data      fp     rr
      vecs[0]  = '{1'b0, 1'b0, 2'b11, 6'o00, 16'h0000, 2'b00, 2'b00};
      vecs[1]  = '{1'b0, 1'b0, 2'b11, 6'o00, 16'h0000, 2'b00, 2'b00};
      vecs[2]  = '{1'b1, 1'b0, 2'b10, 6'o50, 16'hA500, 2'b10, 2'b10};
      vecs[3]  = '{1'b1, 1'b0, 2'b00, 6'o50, 16'hA500, 2'b00, 2'b00};
      vecs[4]  = '{1'b0, 1'b0, 2'b00, 6'o00, 16'h0000, 2'b00, 2'b00};
      vecs[5]  = '{1'b1, 1'b0, 2'b11, 6'o21, 16'h2010, 2'b01, 2'b01};
      vecs[6]  = '{1'b1, 1'b0, 2'b11, 6'o21, 16'h2010, 2'b01, 2'b10};
      vecs[7]  = '{1'b1, 1'b0, 2'b11, 6'o21, 16'h2010, 2'b01, 2'b01};
      vecs[8]  = '{1'b1, 1'b0, 2'b11, 6'o21, 16'h2010, 2'b01, 2'b10};
      vecs[9]  = '{1'b1, 1'b1, 2'b11, 6'o21, 16'h2010, 2'b00, 2'b00};
      vecs[10] = '{1'b1, 1'b1, 2'b11, 6'o21, 16'h2010, 2'b00, 2'b00};
      vecs[11] = '{1'b1, 1'b1, 2'b11, 6'o21, 16'h2010, 2'b00, 2'b00};
      vecs[12] = '{1'b1, 1'b0, 2'b11, 6'o21, 16'h2010, 2'b01, 2'b01};
      vecs[13] = '{1'b1, 1'b0, 2'b00, 6'o21, 16'h2010, 2'b00, 2'b00};

      m_ptr       = '0;
      m_cnt       = 16'd0;
      m_last_reg  = 3'd0;
      m_last_data = 8'd0;

      for (int i = 0; i < 14; i++) begin
         apply(vecs[i]);
         if (i == 2) begin
            chk("t2_reg", {29'd0, regToWrite}, 32'd5);
            chk("t2_data", {24'd0, dataIn}, 32'hA5);
         end
         if (i == 8) chk("t3_cnt4", {16'd0, grantCount}, 32'd4);
         if (i == 11) chk("t5_stall_wr", {31'd0, regWrEn}, 32'd0);
         if (i == 12) chk("t5_resume", {31'd0, regWrEn}, 32'd1);
      end

      // Same destination from both requesters; each drops valid once granted.
      reset = 1'b0; wbStall = 1'b0; reqValid = 2'b00;
      cycle(1'b0, 2'b00);
      reset = 1'b1; reqValid = 2'b11; reqReg = 6'o33; reqData = 16'h2211;
      cycle(1'b1, 2'b01);
      chk("t4_first", {24'd0, dataIn}, 32'h11);
      reqValid = 2'b10;
      cycle(1'b1, 2'b10);
      chk("t4_second", {24'd0, dataIn}, 32'h22);
      chk("t4_reg", {29'd0, regToWrite}, 32'd3);
      reqValid = 2'b00;
      cycle(1'b1, 2'b00);

      // Counter wrap, then reset with a write in flight.
      reset = 1'b0;
      cycle(1'b0, 2'b00);
      reset = 1'b1; reqValid = 2'b11; reqReg = 6'o21; reqData = 16'h2010;
      for (int i = 0; i < 65535; i++) cycle(1'b0, 2'b00);
      chk("t6_cnt_max", {16'd0, grantCount}, 32'hFFFF);
      cycle(1'b0, 2'b00);
      chk("t6_cnt_wrap", {16'd0, grantCount}, 32'h0000);
      chk("t6_inflight", {31'd0, regWrEn}, 32'd1);
      reset = 1'b0;
      cycle(1'b1, 2'b00);
      chk("t6_rst_drop", {31'd0, regWrEn}, 32'd0);
      reset = 1'b1;
      cycle(1'b1, 2'b01);
      chk("t6_resume", {31'd0, regWrEn}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
